enc_16x4_seq: RTL and testbench

ENC_16X4_SEQ -- requirements
Module: enc_16x4_seq

---
 rtl/enc_16x4_seq.sv | 114 +++++++++++
 tb/tb_enc_16x4_seq.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/enc_16x4_seq.sv
// Sequential 16-to-4 priority encoder: captures a request vector and streams
// out one index per set bit over a valid/ready handshake.
module enc_16x4_seq #(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] in_vec,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [3:0]  idx_out,
  output logic [4:0]  cnt_out,
  output logic        zero_out,
  output logic        last_out,
  output logic        out_valid,
  input  logic        out_ready
);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t      state_q, state_d;
  logic [15:0] pend_q, pend_d;
  logic [3:0]  idx_q, idx_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        zero_q, zero_d;
  logic        last_q, last_d;
  logic [15:0] rem;

  function automatic logic [3:0] selIdx(input logic [15:0] v);
    logic [3:0] r;
    r = '0;
    if (LSB_FIRST) begin
      for (int k = 15; k >= 0; k--) begin
        if (v[k]) r = 4'(k);
      end
    end else begin
      for (int k = 0; k < 16; k++) begin
        if (v[k]) r = 4'(k);
      end
    end
    return r;
  endfunction

  function automatic logic [4:0] popCnt(input logic [15:0] v);
    logic [4:0] c;
    c = '0;
    for (int k = 0; k < 16; k++) begin
      c = c + 5'(v[k]);
    end
    return c;
  endfunction

  // The next beat's index and last flag are precomputed so outputs stay registered.
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    zero_d  = zero_q;
    last_d  = last_q;
    rem     = pend_q & ~(16'd1 << idx_q);
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          pend_d  = in_vec;
          cnt_d   = popCnt(in_vec);
          zero_d  = (in_vec == 16'd0);
          idx_d   = selIdx(in_vec);
          last_d  = (popCnt(in_vec) <= 5'd1);
          state_d = EMIT;
        end
      end
      EMIT: begin
        if (out_ready) begin
          if (last_q) begin
            pend_d  = '0;
            state_d = IDLE;
          end else begin
            pend_d = rem;
            idx_d  = selIdx(rem);
            last_d = (popCnt(rem) == 5'd1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pend_q  <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      zero_q  <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      zero_q  <= zero_d;
      last_q  <= last_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == EMIT);
  assign idx_out   = idx_q;
  assign cnt_out   = cnt_q;
  assign zero_out  = zero_q;
  assign last_out  = last_q;

endmodule

// File: tb/tb_enc_16x4_seq.sv
// Scoreboard bench for enc_16x4_seq: LSB-first and MSB-first instances share
// stimulus; a negedge monitor checks every presented beat against hand-built queues.
module tb_enc_16x4_seq;

  typedef struct {
    logic [3:0] idx;
    logic [4:0] cnt;
    logic       zero;
    logic       last;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] in_vec;
  logic        in_valid;
  logic        out_ready;

  logic        readyL, validL, zeroL, lastL;
  logic [3:0]  idxL;
  logic [4:0]  cntL;
  logic        readyM, validM, zeroM, lastM;
  logic [3:0]  idxM;
  logic [4:0]  cntM;

  beat_t qL[$];
  beat_t qM[$];
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  enc_16x4_seq #(.LSB_FIRST(1'b1)) dutL (
    .clk(clk), .rst_n(rst_n), .in_vec(in_vec), .in_valid(in_valid),
    .in_ready(readyL), .idx_out(idxL), .cnt_out(cntL), .zero_out(zeroL),
    .last_out(lastL), .out_valid(validL), .out_ready(out_ready)
  );

  enc_16x4_seq #(.LSB_FIRST(1'b0)) dutM (
    .clk(clk), .rst_n(rst_n), .in_vec(in_vec), .in_valid(in_valid),
    .in_ready(readyM), .idx_out(idxM), .cnt_out(cntM), .zero_out(zeroM),
    .last_out(lastM), .out_valid(validM), .out_ready(out_ready)
  );

  task automatic checkVal(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic pushExp(input bit inst, input int idx, input int cnt, input bit zero, input bit last);
    beat_t b;
    b.idx  = 4'(idx);
    b.cnt  = 5'(cnt);
    b.zero = zero;
    b.last = last;
    if (inst) qM.push_back(b);
    else      qL.push_back(b);
  endtask

  task automatic pushBoth(input int idx, input int cnt, input bit zero, input bit last);
    pushExp(1'b0, idx, cnt, zero, last);
    pushExp(1'b1, idx, cnt, zero, last);
  endtask

  // A stalled beat is compared against the queue head too, so it must not drift.
  task automatic checkOutput(input bit inst, input logic v, input logic [3:0] idx,
                             input logic [4:0] cnt, input logic zero, input logic last);
    beat_t e;
    if (!v) return;
    total++;
    if ((inst ? qM.size() : qL.size()) == 0) begin
      bad++;
      $display("[TB] FAIL beat%s unexpected: idx=%0d cnt=%0d zero=%0d last=%0d, expected no beat",
               inst ? "M" : "L", idx, cnt, zero, last);
      return;
    end
    e = inst ? qM[0] : qL[0];
    if (idx !== e.idx || cnt !== e.cnt || zero !== e.zero || last !== e.last) begin
      bad++;
      $display("[TB] FAIL beat%s: idx=%0d cnt=%0d zero=%0d last=%0d, expected idx=%0d cnt=%0d zero=%0d last=%0d",
               inst ? "M" : "L", idx, cnt, zero, last, e.idx, e.cnt, e.zero, e.last);
    end
    if (out_ready) begin
      if (inst) void'(qM.pop_front());
      else      void'(qL.pop_front());
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      checkOutput(1'b0, validL, idxL, cntL, zeroL, lastL);
      checkOutput(1'b1, validM, idxM, cntM, zeroM, lastM);
    end
  end

  task automatic applyStimulus(input logic [15:0] vec);
    in_vec   = vec;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain(input bit toggle, input int expCycles, input string name);
    int ec;
    bit r, done;
    ec = 0; r = 1'b1; done = 1'b0;
    for (int c = 0; c < 100 && !done; c++) begin
      out_ready = toggle ? r : 1'b1;
      r = !r;
      @(negedge clk);
      if (c == 0) checkVal({name, " latency"}, int'(validL && validM), 1);
      if (!validL && !validM) done = 1'b1;
      else begin
        ec++;
        @(posedge clk); #1;
      end
    end
    if (!done) checkVal({name, " timeout"}, 0, 1);
    checkVal({name, " emit cycles"}, ec, expCycles);
    checkVal({name, " ready after"}, int'(readyL && readyM), 1);
    @(posedge clk); #1;
    out_ready = 1'b1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b1; in_vec = 16'hFFFF; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkVal("reset out_valid", int'(validL | validM), 0);
    checkVal("reset in_ready", int'(readyL & readyM), 1);
    checkVal("reset idx", int'(idxL | idxM), 0);
    checkVal("reset cnt", int'(cntL | cntM), 0);
    checkVal("reset zero/last", int'(zeroL | zeroM | lastL | lastM), 0);
    @(posedge clk); #1;
    rst_n = 1'b1; in_valid = 1'b0; in_vec = 16'h0;
    @(negedge clk);
    checkVal("no capture under reset", int'(validL | validM), 0);
    @(posedge clk); #1;

    for (int k = 0; k < 16; k++) begin
      pushBoth(k, 1, 1'b0, 1'b1);
      applyStimulus(16'd1 << k);
      drain(1'b0, 1, $sformatf("onehot%0d", k));
    end

    pushExp(1'b0, 0, 4, 1'b0, 1'b0);  pushExp(1'b1, 15, 4, 1'b0, 1'b0);
    pushExp(1'b0, 5, 4, 1'b0, 1'b0);  pushExp(1'b1, 10, 4, 1'b0, 1'b0);
    pushExp(1'b0, 10, 4, 1'b0, 1'b0); pushExp(1'b1, 5, 4, 1'b0, 1'b0);
    pushExp(1'b0, 15, 4, 1'b0, 1'b1); pushExp(1'b1, 0, 4, 1'b0, 1'b1);
    applyStimulus(16'h8421);
    drain(1'b0, 4, "h8421");

    pushBoth(0, 0, 1'b1, 1'b1);
    applyStimulus(16'h0000);
    drain(1'b0, 1, "zero");

    for (int k = 0; k < 16; k++) begin
      pushExp(1'b0, k, 16, 1'b0, k == 15);
      pushExp(1'b1, 15 - k, 16, 1'b0, k == 15);
    end
    applyStimulus(16'hFFFF);
    drain(1'b1, 31, "full");

    pushExp(1'b0, 4, 4, 1'b0, 1'b0); pushExp(1'b1, 7, 4, 1'b0, 1'b0);
    pushExp(1'b0, 5, 4, 1'b0, 1'b0); pushExp(1'b1, 6, 4, 1'b0, 1'b0);
    applyStimulus(16'h00F0);
    out_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    checkVal("midreset out_valid", int'(validL | validM), 0);
    checkVal("midreset in_ready", int'(readyL & readyM), 1);
    checkVal("midreset queues drained", qL.size() + qM.size(), 0);
    repeat (4) @(posedge clk);
    #1;

    pushExp(1'b0, 0, 2, 1'b0, 1'b0); pushExp(1'b1, 1, 2, 1'b0, 1'b0);
    pushExp(1'b0, 1, 2, 1'b0, 1'b1); pushExp(1'b1, 0, 2, 1'b0, 1'b1);
    pushBoth(8, 1, 1'b0, 1'b1);
    in_vec = 16'h0003; in_valid = 1'b1;
    @(posedge clk); #1;
    in_vec = 16'h0100;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    checkVal("b2b idle gap valid", int'(validL | validM), 0);
    checkVal("b2b idle gap ready", int'(readyL & readyM), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    drain(1'b0, 1, "b2b second");

    checkVal("final queues empty", qL.size() + qM.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
